// File: rtl/legofpga_bringup_if.sv
// legofpga bring-up sequencer signal bundle.
// master = board/host side, slave = sequencer.
interface legofpga_bringup_if;
  logic       ddr_calib_done;
  logic       phy_lnk_up;
  logic       retry;
  logic       core_rst_n;
  logic       user_lnk_up;
  logic       sys_ready;
  logic [2:0] state;
  logic [1:0] err_code;
  logic [7:0] link_down_cnt;

  modport master (
    output ddr_calib_done,
    output phy_lnk_up,
    output retry,
    input  core_rst_n,
    input  user_lnk_up,
    input  sys_ready,
    input  state,
    input  err_code,
    input  link_down_cnt
  );

  modport slave (
    input  ddr_calib_done,
    input  phy_lnk_up,
    input  retry,
    output core_rst_n,
    output user_lnk_up,
    output sys_ready,
    output state,
    output err_code,
    output link_down_cnt
  );
endinterface

// File: rtl/legofpga_bringup_ctrl.sv
// legofpga PCIe bring-up sequencer: core reset hold,
// DDR4 calibration wait, debounced link-up, error/retry.
module legofpga_bringup_ctrl #(
  parameter int RST_HOLD_CYCLES = 600,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CALIB_TIMEOUT   = 1000000,
  parameter int LINK_TIMEOUT    = 4000000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  legofpga_bringup_if.slave  bus
);

  localparam int M_A  = (RST_HOLD_CYCLES > DEBOUNCE_CYCLES)
                      ? RST_HOLD_CYCLES : DEBOUNCE_CYCLES;
  localparam int M_B  = (CALIB_TIMEOUT > LINK_TIMEOUT)
                      ? CALIB_TIMEOUT : LINK_TIMEOUT;
  localparam int MAXP = (M_A > M_B) ? M_A : M_B;
  localparam int TW   = $clog2(MAXP) + 1;
  localparam int DW   = $clog2(DEBOUNCE_CYCLES) + 1;

  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [TW-1:0] RST_LAST   = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] CALIB_LAST = TW'(CALIB_TIMEOUT - 1);
  localparam logic [TW-1:0] LINK_LAST  = TW'(LINK_TIMEOUT - 1);
  localparam logic [DW-1:0] D_ONE      = DW'(1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_CALIB  = 3'd1,
    S_LINK   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [DW-1:0] r_deb;
  logic          r_core;
  logic          r_user;
  logic          r_ready;
  logic [1:0]    r_err;
  logic [7:0]    r_cnt;

  logic          w_differ;
  logic          w_accept;
  logic [DW-1:0] w_deb_step;

  assign w_differ = bus.phy_lnk_up != r_user;
  assign w_accept = w_differ && (r_deb == DEB_LAST);

  // Debounce run length: holds at the last step so a
  // level that differed long enough is accepted at once.
  always_comb begin
    w_deb_step = '0;
    if (w_differ) begin
      if (r_deb == DEB_LAST) w_deb_step = r_deb;
      else                   w_deb_step = r_deb + D_ONE;
    end
  end

  // Sequencer with registered outputs; every state
  // change restarts the timer.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_RESET;
      r_timer <= '0;
      r_deb   <= '0;
      r_core  <= 1'b0;
      r_user  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 2'd0;
      r_cnt   <= 8'd0;
    end else begin
      r_timer <= r_timer + T_ONE;
      r_deb   <= w_deb_step;
      case (r_state)
        S_RESET: begin
          r_core <= 1'b0;
          if (r_timer == RST_LAST) begin
            r_state <= S_CALIB;
            r_timer <= '0;
            r_core  <= 1'b1;
          end
        end
        S_CALIB: begin
          if (bus.ddr_calib_done) begin
            r_state <= S_LINK;
            r_timer <= '0;
          end else if (r_timer == CALIB_LAST) begin
            r_state <= S_ERROR;
            r_timer <= '0;
            r_deb   <= '0;
            r_err   <= 2'd1;
            r_core  <= 1'b0;
          end
        end
        S_LINK: begin
          if (w_accept) begin
            r_state <= S_ACTIVE;
            r_timer <= '0;
            r_deb   <= '0;
            r_user  <= 1'b1;
            r_ready <= 1'b1;
          end else if (r_timer == LINK_LAST) begin
            r_state <= S_ERROR;
            r_timer <= '0;
            r_deb   <= '0;
            r_err   <= 2'd2;
            r_core  <= 1'b0;
          end
        end
        S_ACTIVE: begin
          if (!bus.ddr_calib_done) begin
            r_state <= S_ERROR;
            r_timer <= '0;
            r_deb   <= '0;
            r_err   <= 2'd3;
            r_core  <= 1'b0;
            r_user  <= 1'b0;
            r_ready <= 1'b0;
          end else if (w_accept) begin
            r_state <= S_LINK;
            r_timer <= '0;
            r_deb   <= '0;
            r_user  <= 1'b0;
            r_ready <= 1'b0;
            if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          end
        end
        S_ERROR: begin
          r_core  <= 1'b0;
          r_user  <= 1'b0;
          r_ready <= 1'b0;
          if (bus.retry) begin
            r_state <= S_RESET;
            r_timer <= '0;
            r_deb   <= '0;
            r_err   <= 2'd0;
          end
        end
        default: begin
          r_state <= S_RESET;
          r_timer <= '0;
          r_deb   <= '0;
          r_core  <= 1'b0;
          r_user  <= 1'b0;
          r_ready <= 1'b0;
          r_err   <= 2'd0;
        end
      endcase
    end
  end

  assign bus.core_rst_n    = r_core;
  assign bus.user_lnk_up   = r_user;
  assign bus.sys_ready     = r_ready;
  assign bus.state         = r_state;
  assign bus.err_code      = r_err;
  assign bus.link_down_cnt = r_cnt;

endmodule

// File: tb/tb_legofpga_bringup_ctrl.sv
// Scoreboard bench for legofpga_bringup_ctrl against a
// cycle-stepped behavioural model of the bring-up rules.
module tb_legofpga_bringup_ctrl;

  localparam int RST = 600;
  localparam int DEB = 4;
  localparam int CT  = 100;
  localparam int LT  = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  legofpga_bringup_if bif();

  legofpga_bringup_ctrl #(
    .RST_HOLD_CYCLES(RST),
    .DEBOUNCE_CYCLES(DEB),
    .CALIB_TIMEOUT(CT),
    .LINK_TIMEOUT(LT)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .bus(bif)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       core;
    logic       user;
    logic       ready;
    logic [1:0] err;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  int m_state, m_timer, m_run, m_err, m_cnt;
  bit m_core, m_user, m_ready;

  task automatic model_reset();
    m_state = 0; m_timer = 0; m_run = 0;
    m_err = 0; m_cnt = 0;
    m_core = 0; m_user = 0; m_ready = 0;
  endtask

  task automatic model_step(input bit d, input bit p, input bit r);
    int ns;
    int run_now;
    bit acc;
    bit flip;
    ns = m_state;
    flip = 0;
    run_now = (p != m_user) ? m_run + 1 : 0;
    acc = run_now >= DEB;
    case (m_state)
      0: if (m_timer == RST - 1) begin ns = 1; m_core = 1; end
      1: begin
        if (d) ns = 2;
        else if (m_timer == CT - 1) begin
          ns = 4; m_err = 1; m_core = 0;
        end
      end
      2: begin
        if (acc) begin
          ns = 3; m_user = 1; m_ready = 1; flip = 1;
        end else if (m_timer == LT - 1) begin
          ns = 4; m_err = 2; m_core = 0;
        end
      end
      3: begin
        if (!d) begin
          ns = 4; m_err = 3; m_core = 0;
          m_user = 0; m_ready = 0;
        end else if (acc) begin
          ns = 2; m_user = 0; m_ready = 0; flip = 1;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
      end
      4: if (r) begin ns = 0; m_err = 0; end
      default: ns = 0;
    endcase
    if (flip || (ns != m_state && (ns == 0 || ns == 4)))
      m_run = 0;
    else
      m_run = run_now;
    m_timer = (ns != m_state) ? 0 : m_timer + 1;
    m_state = ns;
  endtask

  // Called at a falling edge: drive, predict, advance.
  task automatic cyc(input bit d, input bit p, input bit r);
    exp_t e;
    bif.ddr_calib_done = d;
    bif.phy_lnk_up = p;
    bif.retry = r;
    model_step(d, p, r);
    e.st = 3'(m_state);
    e.core = m_core;
    e.user = m_user;
    e.ready = m_ready;
    e.err = 2'(m_err);
    e.cnt = 8'(m_cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic run_n(input int n, input bit d, input bit p);
    for (int i = 0; i < n; i++) cyc(d, p, 1'b0);
  endtask

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  // Monitor: compare each post-edge DUT output against the
  // oldest prediction.
  initial begin
    exp_t e;
    exp_t g;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        g.st = bif.state;
        g.core = bif.core_rst_n;
        g.user = bif.user_lnk_up;
        g.ready = bif.sys_ready;
        g.err = bif.err_code;
        g.cnt = bif.link_down_cnt;
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL scb t=%0t st %0d/%0d core %0b/%0b user %0b/%0b rdy %0b/%0b err %0d/%0d cnt %0d/%0d (got/exp)",
                   $time, g.st, e.st, g.core, e.core, g.user, e.user,
                   g.ready, e.ready, g.err, e.err, g.cnt, e.cnt);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, int'(bif.state), 0);
    chk({tag, "_core_rst_n"}, int'(bif.core_rst_n), 0);
    chk({tag, "_user_lnk_up"}, int'(bif.user_lnk_up), 0);
    chk({tag, "_sys_ready"}, int'(bif.sys_ready), 0);
    chk({tag, "_err_code"}, int'(bif.err_code), 0);
    chk({tag, "_link_down_cnt"}, int'(bif.link_down_cnt), 0);
  endtask

  initial begin
    bif.ddr_calib_done = 0;
    bif.phy_lnk_up = 0;
    bif.retry = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Normal bring-up with noise during the reset hold.
    for (int i = 0; i < 720; i++) begin
      bit p;
      bit r;
      p = (i < 590) ? 1'($urandom_range(0, 1)) : (i >= 700);
      r = ($urandom_range(0, 19) == 0);
      cyc(i >= 50, p, r);
    end

    // Short glitch ignored, full drop counted, relink.
    run_n(3, 1, 0);
    run_n(5, 1, 1);
    run_n(6, 1, 0);
    run_n(6, 1, 1);
    for (int k = 0; k < 20; k++) begin
      run_n($urandom_range(1, 6), 1, 0);
      run_n($urandom_range(4, 10), 1, 1);
    end

    // Calibration loss on the debounce-complete cycle.
    run_n(2, 1, 1);
    run_n(3, 1, 0);
    cyc(0, 0, 0);
    run_n(5, 0, 0);
    cyc(0, 0, 1);

    // Calibration timeout, then retry.
    for (int i = 0; i < 720; i++)
      cyc(0, 1'($urandom_range(0, 1)), 1'b0);
    cyc(0, 0, 1);
    run_n(3, 0, 0);

    // Link timeout, then retry.
    for (int i = 0; i < 820; i++) begin
      bit p;
      p = (i < 580) ? 1'($urandom_range(0, 1)) : 1'b0;
      cyc(1, p, 1'b0);
    end
    cyc(1, 0, 1);

    // Bring up again, then drive the drop counter past 255.
    for (int i = 0; i < 640; i++) cyc(1, i >= 620, 1'b0);
    for (int k = 0; k < 300; k++) begin
      run_n(4, 1, 0);
      run_n(4, 1, 1);
    end
    run_n(4, 1, 0);
    run_n(10, 1, 0);

    // Asynchronous reset in the middle of WAIT_LINK.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_n(30, 1, 1);

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
